// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter/decoder slice: grant-state
// encoding, default widths, slave base addresses and decode field.
package bus_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } grant_e;

    localparam logic [7:0] S0_BASE_DEF = 8'h00;
    localparam logic [7:0] S1_BASE_DEF = 8'h60;

    // Slaves are decoded on the top three address bits.
    localparam int DEC_HI = 7;
    localparam int DEC_LO = 5;

    function automatic logic field_match(
        input logic [7:0] addr,
        input logic [7:0] base
    );
        return addr[DEC_HI:DEC_LO] == base[DEC_HI:DEC_LO];
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Address-to-slave-select decode plus registered-select read-data mux.
// Ports: clk/rst_n, req_valid, address, s0/s1 read data, s0/s1 selects, m_din.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter int         DATA_W  = DATA_W_DEF,
    parameter logic [7:0] S0_BASE = S0_BASE_DEF,
    parameter logic [7:0] S1_BASE = S1_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic              s0_sel,
    output logic              s1_sel,
    output logic [DATA_W-1:0] m_din
);

    logic       hit0;
    logic       hit1;
    logic [1:0] sel_d;
    logic [1:0] sel_q;

    always_comb begin
        hit0   = field_match(address[7:0], S0_BASE);
        hit1   = field_match(address[7:0], S1_BASE);
        s0_sel = req_valid & hit0;
        // s0 wins if both bases were ever configured onto one field.
        s1_sel = req_valid & hit1 & ~hit0;
        sel_d  = {s1_sel, s0_sel};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 2'b00;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Steered by last cycle's select, independent of the current grant.
    always_comb begin
        m_din = '0;
        if (sel_q[0]) begin
            m_din = s0_dout;
        end else if (sel_q[1]) begin
            m_din = s1_dout;
        end
    end

endmodule

// File: rtl/bus_arbiter_decoder.sv
// Two-master bus stage: Moore grant FSM, address/data mux, slave decode.
// Ports: clk, reset_n, m0_*/m1_* master side, s_*/s0_*/s1_* slave side,
// m_din read return. Define BUS_DECERR_EN to add sticky dec_err output.
module bus_arbiter_decoder
    import bus_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter int         DATA_W  = DATA_W_DEF,
    parameter logic [7:0] S0_BASE = S0_BASE_DEF,
    parameter logic [7:0] S1_BASE = S1_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              s0_sel,
    output logic              s1_sel,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_wr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic [DATA_W-1:0] m_din
`ifdef BUS_DECERR_EN
    ,
    output logic              dec_err
`endif
);

    grant_e state_q;
    grant_e state_d;
    logic   m0_grant_q;
    logic   m1_grant_q;
    logic   granted_req;
    logic   req_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            M0_GRANT: if (!m0_req && m1_req) state_d = M1_GRANT;
            M1_GRANT: if (!m1_req) state_d = M0_GRANT;
            default:  state_d = M0_GRANT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= M0_GRANT;
            m0_grant_q <= 1'b1;
            m1_grant_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m0_grant_q <= (state_d == M0_GRANT);
            m1_grant_q <= (state_d == M1_GRANT);
        end
    end

    assign m0_grant = m0_grant_q;
    assign m1_grant = m1_grant_q;

    // Bus is idle while in reset or when the owner is not requesting.
    always_comb begin
        granted_req = (state_q == M1_GRANT) ? m1_req : m0_req;
        req_valid   = granted_req & reset_n;
        s_address   = '0;
        s_wr        = 1'b0;
        s_din       = '0;
        if (req_valid) begin
            if (state_q == M1_GRANT) begin
                s_address = m1_address;
                s_wr      = m1_wr;
                s_din     = m1_dout;
            end else begin
                s_address = m0_address;
                s_wr      = m0_wr;
                s_din     = m0_dout;
            end
        end
    end

    bus_addr_decoder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE)
    ) u_dec (
        .clk       (clk),
        .rst_n     (reset_n),
        .req_valid (req_valid),
        .address   (s_address),
        .s0_dout   (s0_dout),
        .s1_dout   (s1_dout),
        .s0_sel    (s0_sel),
        .s1_sel    (s1_sel),
        .m_din     (m_din)
    );

`ifdef BUS_DECERR_EN
    logic dec_err_q;
    logic dec_err_d;

    always_comb begin
        dec_err_d = dec_err_q | (req_valid & ~s0_sel & ~s1_sel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_err_q <= 1'b0;
        end else begin
            dec_err_q <= dec_err_d;
        end
    end

    assign dec_err = dec_err_q;
`endif

endmodule

// File: doc/bus_arbiter_decoder.md
Name: bus_arbiter_decoder

Overview:
- Shared-bus stage between the two bus masters and the slaves. M0 is the host/testbench port; M1 is the operation-sequencing master whose next-state logic emits `M1_address` and expects `S_sel` and `S_wr`.
- Arbitrates between M0 and M1 with a registered Moore grant FSM.
- Muxes the granted master's address, write-enable and write data onto the slave bus, and decodes the address into per-slave selects.
- Returns read data through a registered-select mux.

Parameters:
- ADDR_W, 8, bus address width
- DATA_W, 32, bus data width
- S0_BASE, 8'h00, slave0 base; matched on address[7:5]
- S1_BASE, 8'h60, slave1 base; matched on address[7:5] (covers 0x60..0x7F)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  master0 bus request
- m0_wr  in  1  master0 write enable (1 = write)
- m0_address  in  ADDR_W  master0 address
- m0_dout  in  DATA_W  master0 write data
- m1_req  in  1  master1 bus request
- m1_wr  in  1  master1 write enable
- m1_address  in  ADDR_W  master1 address
- m1_dout  in  DATA_W  master1 write data
- m0_grant  out  1  master0 owns bus
- m1_grant  out  1  master1 owns bus
- s0_sel  out  1  slave0 select
- s1_sel  out  1  slave1 select
- s_address  out  ADDR_W  bus address to slaves
- s_wr  out  1  bus write enable to slaves
- s_din  out  DATA_W  bus write data to slaves
- s0_dout  in  DATA_W  slave0 read data (valid the cycle after select)
- s1_dout  in  DATA_W  slave1 read data
- m_din  out  DATA_W  read data returned to masters

Behaviour:
- Clock/reset: single clock `clk`; reset is asynchronous, active-low (`reset_n`). All flops clear immediately on `reset_n`=0.
- Grant FSM has two states, M0_GRANT (reset state) and M1_GRANT.
  - M0_GRANT: go to M1_GRANT iff m0_req=0 and m1_req=1; otherwise stay.
  - M1_GRANT: go to M0_GRANT iff m1_req=0; otherwise stay. M1 holds the bus for as long as it requests, with no preemption.
  - Simultaneous m0_req=1 and m1_req=1 in M0_GRANT: stay in M0_GRANT (M0 has priority).
- Grant outputs are Moore: m0_grant = (state==M0_GRANT), m1_grant = (state==M1_GRANT). Exactly one is high at all times.
  - Reset values: m0_grant=1, m1_grant=0.
- Grant latency: a request raised while the bus is free is granted on the next rising edge.
- Bus mux (combinational from state):
  - M0_GRANT: s_address, s_wr and s_din follow the M0 inputs.
  - M1_GRANT: they follow the M1 inputs.
  - Reset/idle values: s_address=0, s_wr=0, s_din=0 when the granted master's req=0.
- Decode (combinational), gated by the granted master's req:
  - s0_sel=1 iff s_address[7:5]==S0_BASE[7:5].
  - s1_sel=1 iff s_address[7:5]==S1_BASE[7:5].
  - At most one select is high. Any other address produces no select.
- Read path: a 2-bit register captures {s1_sel, s0_sel} each cycle (reset 0).
  - m_din = s0_dout if the registered s0 bit is set, s1_dout if the registered s1 bit is set, otherwise 0.
  - Read latency is one cycle after the select cycle.
- Grant change while a read is in flight: the registered select still steers m_din for that one cycle. m_din is not gated by grant.
- Reset mid-transfer: the FSM returns to M0_GRANT and the registered select clears, so m_din=0.

Optional Feature:
- Macro: BUS_DECERR_EN.
- Defined: adds output `dec_err` (1 bit).
  - Registered and sticky; set on a cycle where the granted master has req=1 and no slave select decodes.
  - Cleared only by reset (`dec_err`=0 at reset).
  - The failing access itself completes with no select and m_din=0 the next cycle.
- Undefined: no `dec_err` port; unmapped accesses are silently ignored.

Decomposition:
- Shared package `bus_pkg`:
  - grant-state encoding (M0_GRANT=1'b0, M1_GRANT=1'b1)
  - ADDR_W and DATA_W defaults
  - slave base constants 8'h00 and 8'h60
  - decode field slice [7:5]
- One sub-module, `bus_addr_decoder`: combinational address-to-select decode, plus a registered select/read-data mux. It is reusable when more slaves are added.
- Arbiter FSM and bus mux stay in the top.

Test Plan:
- Reset: hold reset_n=0 with random inputs → m0_grant=1, m1_grant=0, s0_sel=s1_sel=0, m_din=0. Release with no requests → outputs unchanged.
- Handover and priority:
  - m0_req=0, m1_req=1 → m1_grant=1 next edge.
  - Then raise m0_req=1 while m1_req stays 1 → grant stays M1.
  - Drop m1_req → m0_grant=1 next edge.
- M1 write: M1 granted, m1_req=1, m1_wr=1, m1_address=8'h60, m1_dout=32'h5 → s1_sel=1, s_wr=1, s_address=8'h60, s_din=32'h5 in the same cycle.
- Read steering:
  - M0 reads 8'h06 with s0_dout=32'hA5A5 → m_din=32'hA5A5 one cycle later.
  - M0 reads 8'h61 with s1_dout=32'h1234 → m_din=32'h1234 one cycle later.
- Unmapped access: m0 reads 8'h40 → no select, m_din=0 next cycle. With BUS_DECERR_EN, dec_err=1 from the next edge and stays 1 through later valid accesses until reset.
- Mid-transfer reset: assert reset_n=0 asynchronously mid-cycle while M1 is granted → m1_grant=0 and m0_grant=1 immediately, without waiting for a clock edge.
